// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and address type for the register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned NUM_REGS_DEF = 8;

  function automatic int unsigned addr_w(input int unsigned n);
    return $clog2(n);
  endfunction

  typedef logic [addr_w(NUM_REGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback side bundle of the register file: read ports, write port, issue and scoreboard.
interface regfile_scoreboard_if import regfile_pkg::*; #(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) ();

  localparam int unsigned ADDR_W = addr_w(NUM_REGS);

  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                issue_en;
  logic [ADDR_W-1:0]   issue_addr;
  logic                flush;
  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    input  rd_data_a, rd_data_b, stall, busy_vec
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    output rd_data_a, rd_data_b, stall, busy_vec
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking with flush > issue > writeback priority and hazard stall.
module reg_scoreboard import regfile_pkg::*; #(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic                flush,
  output logic                stall_c,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] eff_busy;
  logic                issue_ok;

  // A register being written back this cycle no longer blocks when its data is forwarded.
  always_comb begin
    eff_busy = busy;
    if (BYPASS && wr_en) eff_busy[wr_addr] = 1'b0;
    if (ZERO_REG) eff_busy[0] = 1'b0;
  end

  assign stall_c = ~rst & issue_en &
                   (eff_busy[rd_addr_a] | eff_busy[rd_addr_b] | eff_busy[issue_addr]);

  assign issue_ok = issue_en & ~stall_c & ~flush &
                    ~(ZERO_REG && (issue_addr == ADDR_W'(0)));

  // Issue is applied after writeback so a new producer keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)    busy_nxt[wr_addr]    = 1'b0;
      if (issue_ok) busy_nxt[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write bypass, optional zero register and busy scoreboard.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned ADDR_W = addr_w(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Zero register beats bypass; reset forces every read to zero.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              in_rst,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (BYPASS && wen && (waddr == addr)) val = wdata;
    if (ZERO_REG && (addr == ADDR_W'(0))) val = '0;
    if (in_rst) val = '0;
    return val;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (bus.wr_en && !(ZERO_REG && (bus.wr_addr == ADDR_W'(0)))) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    bus.rd_data_a = read_mux(rst, bus.rd_addr_a, regs[bus.rd_addr_a],
                             bus.wr_en, bus.wr_addr, bus.wr_data);
    bus.rd_data_b = read_mux(rst, bus.rd_addr_b, regs[bus.rd_addr_b],
                             bus.wr_en, bus.wr_addr, bus.wr_data);
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .rd_addr_a  (bus.rd_addr_a),
    .rd_addr_b  (bus.rd_addr_b),
    .flush      (bus.flush),
    .stall_c    (bus.stall),
    .busy       (bus.busy_vec)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of the register file: reads, zero reg, bypass, hazards, flush and async reset.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(16), .NUM_REGS(8)) ifa ();
  regfile_scoreboard_if #(.DATA_W(16), .NUM_REGS(8)) ifb ();

  // Default build and a no-bypass build fed the same stimulus.
  regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut (.clk(clk), .rst(rst), .bus(ifa));
  regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_nb (.clk(clk), .rst(rst), .bus(ifb));

  assign ifb.rd_addr_a  = ifa.rd_addr_a;
  assign ifb.rd_addr_b  = ifa.rd_addr_b;
  assign ifb.wr_en      = ifa.wr_en;
  assign ifb.wr_addr    = ifa.wr_addr;
  assign ifb.wr_data    = ifa.wr_data;
  assign ifb.issue_en   = ifa.issue_en;
  assign ifb.issue_addr = ifa.issue_addr;
  assign ifb.flush      = ifa.flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ifa.rd_addr_a  = 3'd0;
    ifa.rd_addr_b  = 3'd0;
    ifa.wr_en      = 1'b0;
    ifa.wr_addr    = 3'd0;
    ifa.wr_data    = 16'h0;
    ifa.issue_en   = 1'b0;
    ifa.issue_addr = 3'd0;
    ifa.flush      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    idle();
    ifa.wr_en   = 1'b1;
    ifa.wr_addr = a;
    ifa.wr_data = d;
    step();
  endtask

  initial begin
    idle();
    #2 rst = 1'b1;
    // Reset: outputs zero even with a write aimed at the read address
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd1; ifa.wr_data = 16'hAAAA; ifa.rd_addr_a = 3'd1;
    ifa.issue_en = 1'b1; ifa.issue_addr = 3'd1;
    #1;
    check("rst_rd_a",  32'(ifa.rd_data_a), 32'h0);
    check("rst_busy",  32'(ifa.busy_vec),  32'h0);
    check("rst_stall", 32'(ifa.stall),     32'h0);
    step();
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();

    // Plain write then read
    write(3'd3, 16'h1234);
    write(3'd5, 16'hBEEF);
    idle(); ifa.rd_addr_a = 3'd3; ifa.rd_addr_b = 3'd5; #1;
    check("rd_r3", 32'(ifa.rd_data_a), 32'h1234);
    check("rd_r5", 32'(ifa.rd_data_b), 32'hBEEF);

    // Zero register ignores writes and issues
    write(3'd0, 16'hFFFF);
    idle(); ifa.rd_addr_a = 3'd0; ifa.issue_en = 1'b1; ifa.issue_addr = 3'd0; #1;
    check("rd_r0",       32'(ifa.rd_data_a), 32'h0);
    check("r0_issue_st", 32'(ifa.stall),     32'h0);
    step();
    check("r0_issue_bv", 32'(ifa.busy_vec),  32'h0);

    // Same-cycle bypass vs. no-bypass build
    idle(); ifa.wr_en = 1'b1; ifa.wr_addr = 3'd2; ifa.wr_data = 16'h00AA; ifa.rd_addr_a = 3'd2; #1;
    check("byp_rd",    32'(ifa.rd_data_a), 32'h00AA);
    check("nobyp_rd",  32'(ifb.rd_data_a), 32'h0000);
    step();
    idle(); ifa.rd_addr_a = 3'd2; #1;
    check("nobyp_rd2", 32'(ifb.rd_data_a), 32'h00AA);

    // RAW hazard resolved by same-cycle writeback
    idle(); ifa.issue_en = 1'b1; ifa.issue_addr = 3'd4; #1;
    check("raw_iss_st", 32'(ifa.stall), 32'h0);
    step();
    check("raw_bv", 32'(ifa.busy_vec), 32'h10);
    idle(); ifa.issue_en = 1'b1; ifa.issue_addr = 3'd4; ifa.rd_addr_a = 3'd4; #1;
    check("raw_stall", 32'(ifa.stall), 32'h1);
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd4; ifa.wr_data = 16'h4444; #1;
    check("raw_wb_st",    32'(ifa.stall),     32'h0);
    check("raw_wb_rd",    32'(ifa.rd_data_a), 32'h4444);
    check("raw_nb_st",    32'(ifb.stall),     32'h1);
    step();
    check("raw_bv2",      32'(ifa.busy_vec),  32'h10);
    check("raw_nb_bv2",   32'(ifb.busy_vec),  32'h00);
    write(3'd4, 16'h4545);
    check("raw_clr_bv",   32'(ifa.busy_vec),  32'h00);

    // WAW: issue wins over same-cycle writeback to the same register
    idle(); ifa.issue_en = 1'b1; ifa.issue_addr = 3'd6;
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd6; ifa.wr_data = 16'h0606; #1;
    check("waw_st", 32'(ifa.stall), 32'h0);
    step();
    check("waw_bv",    32'(ifa.busy_vec), 32'h40);
    check("waw_nb_bv", 32'(ifb.busy_vec), 32'h40);
    idle(); ifa.issue_en = 1'b1; ifa.issue_addr = 3'd6; #1;
    check("waw_st2", 32'(ifa.stall), 32'h1);
    step();
    check("waw_bv2", 32'(ifa.busy_vec), 32'h40);

    // Build busy_vec = 0x3C while retiring r6
    idle(); ifa.issue_en = 1'b1; ifa.issue_addr = 3'd2;
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd6; ifa.wr_data = 16'h6666;
    step();
    for (int r = 3; r <= 5; r++) begin
      idle(); ifa.issue_en = 1'b1; ifa.issue_addr = 3'(r);
      step();
    end
    check("fl_pre_bv", 32'(ifa.busy_vec), 32'h3C);

    // Flush drops the issue but keeps the write
    idle(); ifa.flush = 1'b1; ifa.issue_en = 1'b1; ifa.issue_addr = 3'd1;
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd2; ifa.wr_data = 16'h0055;
    step();
    check("fl_bv",    32'(ifa.busy_vec), 32'h0);
    check("fl_nb_bv", 32'(ifb.busy_vec), 32'h0);
    idle(); ifa.rd_addr_a = 3'd2; #1;
    check("fl_rd_r2", 32'(ifa.rd_data_a), 32'h0055);

    // Asynchronous reset mid-operation
    idle(); ifa.issue_en = 1'b1; ifa.issue_addr = 3'd7;
    step();
    check("pre_rst_bv", 32'(ifa.busy_vec), 32'h80);
    idle(); ifa.rd_addr_a = 3'd2; ifa.rd_addr_b = 3'd7; ifa.issue_en = 1'b1; ifa.issue_addr = 3'd1; #1;
    check("pre_rst_st", 32'(ifa.stall),     32'h1);
    check("pre_rst_rd", 32'(ifa.rd_data_a), 32'h0055);
    rst = 1'b1; #1;
    check("mid_rst_rd", 32'(ifa.rd_data_a), 32'h0);
    check("mid_rst_bv", 32'(ifa.busy_vec),  32'h0);
    check("mid_rst_st", 32'(ifa.stall),     32'h0);
    step();
    idle();
    @(negedge clk);
    rst = 1'b0;
    ifa.rd_addr_a = 3'd2; #1;
    check("post_rst_rd", 32'(ifa.rd_data_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
